// File: rtl/fm_matrix_pkg.sv
// Shared types and sizing for the FM operator sequencer.
// NOPS must be a power of two so that the operator counter wraps naturally.
package fm_matrix_pkg;

  localparam int NOPS = 8;
  localparam int DW   = 32;
  localparam int AW   = 12;
  localparam int IW   = DW - AW;
  localparam int OPW  = $clog2(NOPS);

  typedef logic [OPW-1:0] op_idx_t;
  typedef logic [DW-1:0]  phase_t;
  typedef logic [AW-1:0]  addr_t;
  typedef logic [IW-1:0]  interp_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  localparam op_idx_t LAST_OP = op_idx_t'(NOPS - 1);

endpackage

// File: rtl/fm_op_sequencer_if.sv
// Beat stream from the sequencer to the wavetable/interpolation stage.
interface fm_op_sequencer_if;
  import fm_matrix_pkg::*;

  logic    out_valid;
  logic    out_ready;
  op_idx_t out_op;
  addr_t   out_addr;
  interp_t out_interp;

  modport master (output out_valid, out_op, out_addr, out_interp, input out_ready);
  modport slave  (input out_valid, out_op, out_addr, out_interp, output out_ready);

endinterface

// File: rtl/op_param_bank.sv
// Per-operator increment, offset and FM registers: control-bus and mixer
// write ports, one combinational read port selected by operator index.
module op_param_bank
  import fm_matrix_pkg::*;
(
  input  logic    Clk,
  input  logic    Reset,
  input  logic    cfg_we,
  input  op_idx_t cfg_op,
  input  logic    cfg_sel,
  input  phase_t  cfg_wdata,
  input  logic    fm_we,
  input  op_idx_t fm_op,
  input  phase_t  fm_wdata,
  input  op_idx_t rd_op,
  output phase_t  rd_inc,
  output phase_t  rd_offset,
  output phase_t  rd_fm
);

  phase_t r_inc    [NOPS];
  phase_t r_offset [NOPS];
  phase_t r_fm     [NOPS];

  // NOTE: the arrays are reset on purpose so every operator is silent after
  // Reset; that forces flops rather than a RAM macro.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < NOPS; k++) begin
        r_inc[k]    <= '0;
        r_offset[k] <= '0;
        r_fm[k]     <= '0;
      end
    end else begin
      if (cfg_we) begin
        if (cfg_sel) r_offset[cfg_op] <= cfg_wdata;
        else         r_inc[cfg_op]    <= cfg_wdata;
      end
      if (fm_we) r_fm[fm_op] <= fm_wdata;
    end
  end

  assign rd_inc    = r_inc[rd_op];
  assign rd_offset = r_offset[rd_op];
  assign rd_fm     = r_fm[rd_op];

endmodule

// File: rtl/fm_op_sequencer.sv
// Time-multiplexed phasor sequencer: one beat per operator per sample_tick.
// Optional build macro FM_OP_HARDSYNC_EN adds the sync_mask hard-sync input.
module fm_op_sequencer
  import fm_matrix_pkg::*;
(
  input  logic    Clk,
  input  logic    Reset,
  input  logic    En,
  input  logic    sample_tick,
  input  logic    cfg_we,
  input  op_idx_t cfg_op,
  input  logic    cfg_sel,
  input  phase_t  cfg_wdata,
  input  logic    fm_we,
  input  op_idx_t fm_op,
  input  phase_t  fm_wdata,
`ifdef FM_OP_HARDSYNC_EN
  input  logic [NOPS-1:0] sync_mask,
`endif
  fm_op_sequencer_if.master out_if,
  output logic    busy,
  output logic    sample_done,
  output logic    overrun
);

  seq_state_t r_state, w_state_nxt;
  op_idx_t    r_op;
  logic       r_issued_all;
  phase_t     r_phase [NOPS];
  logic       r_valid;
  op_idx_t    r_out_op;
  addr_t      r_addr;
  interp_t    r_interp;
  logic       r_overrun;

  phase_t w_inc, w_offset, w_fm;
  phase_t w_pa, w_phase_nxt;
  logic   w_tick, w_accept, w_last_accept, w_load, w_start;

  op_param_bank u_bank (
    .Clk       (Clk),
    .Reset     (Reset),
    .cfg_we    (cfg_we),
    .cfg_op    (cfg_op),
    .cfg_sel   (cfg_sel),
    .cfg_wdata (cfg_wdata),
    .fm_we     (fm_we),
    .fm_op     (fm_op),
    .fm_wdata  (fm_wdata),
    .rd_op     (r_op),
    .rd_inc    (w_inc),
    .rd_offset (w_offset),
    .rd_fm     (w_fm)
  );

  assign w_tick        = sample_tick & En;
  assign w_accept      = r_valid & out_if.out_ready;
  assign w_last_accept = w_accept & (r_out_op == LAST_OP) & (r_state == RUN);
  assign w_load        = En & (r_state == RUN) & ~r_issued_all & (~r_valid | out_if.out_ready);

`ifdef FM_OP_HARDSYNC_EN
  logic [NOPS-1:0] r_sync_mask;

  always_ff @(posedge Clk) begin
    if (Reset)        r_sync_mask <= '0;
    else if (w_start) r_sync_mask <= sync_mask;
  end

  // A synced operator restarts from phase 0 for this sample's beat.
  always_comb begin
    if (r_sync_mask[r_op]) begin
      w_pa        = w_offset;
      w_phase_nxt = w_inc + w_fm;
    end else begin
      w_pa        = r_phase[r_op] + w_offset;
      w_phase_nxt = r_phase[r_op] + w_inc + w_fm;
    end
  end
`else
  assign w_pa        = r_phase[r_op] + w_offset;
  assign w_phase_nxt = r_phase[r_op] + w_inc + w_fm;
`endif

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state_nxt = RUN;
          w_start     = 1'b1;
        end
      end
      RUN: begin
        // Acceptance of the final beat ends the sample even with En low;
        // a tick in that same cycle chains straight into the next sample.
        if (w_last_accept) begin
          w_state_nxt = w_tick ? RUN : IDLE;
          w_start     = w_tick;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_op         <= '0;
      r_issued_all <= 1'b0;
      r_valid      <= 1'b0;
      r_out_op     <= '0;
      r_addr       <= '0;
      r_interp     <= '0;
      r_overrun    <= 1'b0;
      for (int k = 0; k < NOPS; k++) r_phase[k] <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start) begin
        r_op         <= '0;
        r_issued_all <= 1'b0;
      end else if (w_load) begin
        r_op <= r_op + op_idx_t'(1);
        if (r_op == LAST_OP) r_issued_all <= 1'b1;
      end

      if (w_load) begin
        r_valid        <= 1'b1;
        r_out_op       <= r_op;
        r_addr         <= w_pa[DW-1:IW];
        r_interp       <= w_pa[IW-1:0];
        r_phase[r_op]  <= w_phase_nxt;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (w_tick & (r_state == RUN) & ~w_last_accept) r_overrun <= 1'b1;
    end
  end

  assign out_if.out_valid  = r_valid;
  assign out_if.out_op     = r_out_op;
  assign out_if.out_addr   = r_addr;
  assign out_if.out_interp = r_interp;
  assign busy              = (r_state == RUN);
  assign sample_done       = w_last_accept;
  assign overrun           = r_overrun;

endmodule

// File: tb/tb_fm_op_sequencer.sv
// Scoreboard bench for fm_op_sequencer: a reference phase model queues the
// expected beats on every accepted tick; a negedge monitor retires them.
module tb_fm_op_sequencer;
  import fm_matrix_pkg::*;

  logic    Clk = 1'b0;
  logic    Reset, En, sample_tick;
  logic    cfg_we, cfg_sel, fm_we;
  op_idx_t cfg_op, fm_op;
  phase_t  cfg_wdata, fm_wdata;
  logic    busy, sample_done, overrun;
`ifdef FM_OP_HARDSYNC_EN
  logic [NOPS-1:0] sync_mask = '0;
`endif

  fm_op_sequencer_if out_if ();

  fm_op_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .En          (En),
    .sample_tick (sample_tick),
    .cfg_we      (cfg_we),
    .cfg_op      (cfg_op),
    .cfg_sel     (cfg_sel),
    .cfg_wdata   (cfg_wdata),
    .fm_we       (fm_we),
    .fm_op       (fm_op),
    .fm_wdata    (fm_wdata),
`ifdef FM_OP_HARDSYNC_EN
    .sync_mask   (sync_mask),
`endif
    .out_if      (out_if),
    .busy        (busy),
    .sample_done (sample_done),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    op_idx_t op;
    phase_t  pa;
  } beat_t;

  beat_t  sb [$];
  phase_t m_phase [NOPS];
  phase_t m_inc   [NOPS];
  phase_t m_off   [NOPS];
  phase_t m_fm    [NOPS];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // NOTE: inputs change 1 time unit after the rising edge, so the DUT never
  // races the bench and the negedge monitor sees settled values.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NOPS; k++) begin
      m_phase[k] = '0;
      m_inc[k]   = '0;
      m_off[k]   = '0;
      m_fm[k]    = '0;
    end
    sb.delete();
  endtask

  task automatic cfg_write(input int op, input logic sel, input phase_t data);
    cfg_we = 1'b1; cfg_op = op_idx_t'(op); cfg_sel = sel; cfg_wdata = data;
    step();
    cfg_we = 1'b0;
    if (sel) m_off[op] = data;
    else     m_inc[op] = data;
  endtask

  task automatic push_sample();
    for (int k = 0; k < NOPS; k++) begin
      beat_t  b;
      phase_t base;
      base = m_phase[k];
`ifdef FM_OP_HARDSYNC_EN
      if (sync_mask[k]) base = '0;
`endif
      b.op = op_idx_t'(k);
      b.pa = base + m_off[k];
      sb.push_back(b);
      m_phase[k] = base + m_inc[k] + m_fm[k];
    end
  endtask

  task automatic start_tick();
    sample_tick = 1'b1;
    push_sample();
    step();
    sample_tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      step();
      cycles++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_op(input string tag, input int op);
    int n;
    n = 0;
    while (!(out_if.out_valid && out_if.out_op == op_idx_t'(op)) && n < 40) begin
      step();
      n++;
    end
    check({tag, "_reach_op"}, out_if.out_op, op_idx_t'(op));
  endtask

  always @(negedge Clk) begin
    if (!Reset && out_if.out_valid && out_if.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", out_if.out_valid, 1'b0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat_op", out_if.out_op, e.op);
        check("beat_addr", out_if.out_addr, e.pa[DW-1:IW]);
        check("beat_interp", out_if.out_interp, e.pa[IW-1:0]);
        check("beat_sample_done", sample_done, e.op == LAST_OP);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int      cyc;
    op_idx_t hold_op;
    addr_t   hold_addr;
    interp_t hold_interp;

    Reset = 1'b1; En = 1'b1; sample_tick = 1'b0;
    cfg_we = 1'b0; cfg_op = '0; cfg_sel = 1'b0; cfg_wdata = '0;
    fm_we = 1'b0; fm_op = '0; fm_wdata = '0;
    out_if.out_ready = 1'b1;
    model_reset();
    step(); step();
    Reset = 1'b0;
    check("rst_valid", out_if.out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_done", sample_done, 1'b0);
    check("rst_addr", out_if.out_addr, '0);

    // Test 1: inc[k] = k<<20, two samples at full throughput.
    for (int k = 0; k < NOPS; k++) cfg_write(k, 1'b0, phase_t'(k) << 20);
    start_tick();
    check("t1_busy", busy, 1'b1);
    wait_idle("t1a", cyc);
    check("t1_cycles", cyc, NOPS + 1);
    start_tick();
    wait_idle("t1b", cyc);

    // Test 2: large increment on op0 wraps the phase over 17 samples.
    cfg_write(0, 1'b0, 32'hFFF0_0000);
    repeat (17) begin
      start_tick();
      wait_idle("t2", cyc);
    end

    // Test 3: 5-cycle stall on op2; beat must hold and the order resume.
    start_tick();
    wait_op("t3", 2);
    out_if.out_ready = 1'b0;
    hold_op = out_if.out_op; hold_addr = out_if.out_addr; hold_interp = out_if.out_interp;
    repeat (5) begin
      step();
      check("t3_valid", out_if.out_valid, 1'b1);
      check("t3_op", out_if.out_op, hold_op);
      check("t3_addr", out_if.out_addr, hold_addr);
      check("t3_interp", out_if.out_interp, hold_interp);
    end
    out_if.out_ready = 1'b1;
    wait_idle("t3", cyc);
    start_tick();
    wait_idle("t3b", cyc);

    // Test 4a: tick in the sample_done cycle chains a new sample.
    start_tick();
    cyc = 0;
    while (!sample_done && cyc < 30) begin
      step();
      cyc++;
    end
    check("t4_done_seen", sample_done, 1'b1);
    start_tick();
    check("t4_chain_busy", busy, 1'b1);
    check("t4_chain_overrun", overrun, 1'b0);
    wait_idle("t4a", cyc);
    check("t4_overrun_clear", overrun, 1'b0);

    // En low mid-sample: output drains, sequencing freezes, ticks ignored.
    start_tick();
    step();
    En = 1'b0;
    step(); step();
    check("en_valid_drained", out_if.out_valid, 1'b0);
    check("en_busy_hold", busy, 1'b1);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("en_tick_no_overrun", overrun, 1'b0);
    En = 1'b1;
    wait_idle("en", cyc);
    En = 1'b0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    En = 1'b1;
    check("en_idle_tick_ignored", busy, 1'b0);

    // Test 4b: tick while busy sets sticky overrun without disturbing the run.
    start_tick();
    step(); step(); step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("t4_overrun_set", overrun, 1'b1);
    wait_idle("t4b", cyc);
    check("t4_overrun_sticky", overrun, 1'b1);

    // Test 5: same-cycle cfg and fm writes to op1; fm cancels the increment.
    cfg_we = 1'b1; cfg_op = 3'd1; cfg_sel = 1'b1; cfg_wdata = 32'h8000_0000;
    fm_we  = 1'b1; fm_op  = 3'd1; fm_wdata = -m_inc[1];
    step();
    cfg_we = 1'b0; fm_we = 1'b0;
    m_off[1] = 32'h8000_0000;
    m_fm[1]  = -m_inc[1];
    repeat (3) begin
      start_tick();
      wait_idle("t5", cyc);
    end

    // Test 6: Reset at op4 aborts the sample and clears all state.
    start_tick();
    wait_op("t6", 4);
    Reset = 1'b1;
    model_reset();
    step();
    Reset = 1'b0;
    check("t6_valid", out_if.out_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_overrun", overrun, 1'b0);
    cfg_write(5, 1'b1, 32'h1230_0000);
    cfg_write(2, 1'b0, 32'h0040_0000);
    repeat (2) begin
      start_tick();
      wait_idle("t6", cyc);
    end

`ifdef FM_OP_HARDSYNC_EN
    // Hard sync on op0: its beat uses phase 0, so addr = offset>>IW.
    cfg_write(0, 1'b0, 32'h0123_4567);
    start_tick();
    wait_idle("hs_pre", cyc);
    cfg_write(0, 1'b1, 32'h5550_0000);
    sync_mask = 8'h01;
    start_tick();
    sync_mask = '0;
    wait_idle("hs", cyc);
    start_tick();
    wait_idle("hs_post", cyc);
`endif

    step(); step();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
